// File: rtl/sram_pkg.sv
// Shared sizing defaults and write-control state encoding for the 128x32 SRAM.
package sram_pkg;

    localparam int unsigned SRAM_ADDR_W = 7;
    localparam int unsigned SRAM_DEPTH  = 2 ** SRAM_ADDR_W;
    localparam int unsigned SRAM_DATA_W = 32;

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

endpackage

// File: rtl/pulse_edge_det.sv
// One-bit registered edge detector: compares the current sample with the
// previous-cycle sample. History clears on reset so a held-high input reads as a rise.
module pulse_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= sig;
        end
    end

    assign rise = sig & ~prev;
    assign fall = ~sig & prev;

endmodule

// File: rtl/sram_128x32.sv
// Single-port register-array SRAM driven by level strobes: read on read_pulse rise,
// write window framed by write_pulse high, committed when the strobe drops.
module sram_128x32
    import sram_pkg::*;
#(
    parameter int unsigned DEPTH  = SRAM_DEPTH,
    parameter int unsigned ADDR_W = SRAM_ADDR_W,
    parameter int unsigned DATA_W = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              addr_ready,
    input  logic              read_pulse,
    input  logic              write_pulse,
    input  logic [DATA_W-1:0] datain,
    output logic [DATA_W-1:0] dataout
);

    state_t state, next_state;

    logic read_rise, unused_read_fall;
    logic write_rise, write_fall;
    logic arm, capture, commit;

    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] mem [DEPTH];

    pulse_edge_det u_read_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .sig  (read_pulse),
        .rise (read_rise),
        .fall (unused_read_fall)
    );

    pulse_edge_det u_write_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .sig  (write_pulse),
        .rise (write_rise),
        .fall (write_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // WRITE is only entered on a high sample, so its first low sample is always a fall.
    always_comb begin
        next_state = state;
        arm        = 1'b0;
        capture    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (write_rise && addr_ready) begin
                    arm        = 1'b1;
                    capture    = 1'b1;
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (write_fall) begin
                    commit     = 1'b1;
                    next_state = IDLE;
                end else begin
                    capture = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
            wr_data <= '0;
            dataout <= '0;
        end else begin
            if (arm) begin
                wr_addr <= addr;
            end
            if (capture) begin
                wr_data <= datain;
            end
            if (read_rise && addr_ready) begin
                dataout <= mem[addr];
            end
        end
    end

    // Array is deliberately unreset; a same-edge read sees the pre-commit word.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_sram_128x32.sv
// Directed and randomized checks of sram_128x32 against a word-array reference model.
module tb_sram_128x32;

    logic        clk;
    logic        rst_n;
    logic [6:0]  addr;
    logic        addr_ready;
    logic        read_pulse;
    logic        write_pulse;
    logic [31:0] datain;
    logic [31:0] dataout;

    logic [31:0] ref_mem [128];
    logic [31:0] ref_dout;
    int          assert_count;
    int          fail_count;

    sram_128x32 #(.DEPTH(128), .ADDR_W(7), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .addr_ready (addr_ready),
        .read_pulse (read_pulse),
        .write_pulse(write_pulse),
        .datain     (datain),
        .dataout    (dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Single-cycle write window; the model commits only when the window was accepted.
    task automatic do_write(input logic [6:0] a, input logic [31:0] d, input logic rdy);
        write_pulse = 1'b1; addr = a; addr_ready = rdy; datain = d;
        tick();
        write_pulse = 1'b0; addr_ready = 1'b0;
        tick();
        if (rdy) ref_mem[a] = d;
    endtask

    task automatic do_read(input logic [6:0] a, input logic rdy, input string tag);
        read_pulse = 1'b1; addr = a; addr_ready = rdy;
        tick();
        if (rdy) ref_dout = ref_mem[a];
        check(tag, dataout, ref_dout);
        read_pulse = 1'b0; addr_ready = 1'b0;
        tick();
        check({tag, "_hold"}, dataout, ref_dout);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] old;
        logic [6:0]  a;
        logic        rdy;
        int          extra;

        assert_count = 0;
        fail_count   = 0;
        ref_dout     = '0;
        rst_n = 1'b0; addr = '0; addr_ready = 1'b0;
        read_pulse = 1'b0; write_pulse = 1'b0; datain = '0;
        repeat (3) tick();
        check("reset_dataout", dataout, 32'h0);
        rst_n = 1'b1;
        tick();

        // Fill all addresses with distinct words (low 7 bits = address), then read back.
        for (int i = 0; i < 128; i++) begin
            d = ($urandom() & 32'hFFFF_FF80) | 32'(i);
            do_write(7'(i), d, 1'b1);
        end
        for (int i = 0; i < 128; i++) begin
            read_pulse = 1'b1; addr = 7'(i); addr_ready = 1'b1;
            tick();
            ref_dout = ref_mem[i];
            check("fill_read", dataout, ref_dout);
            read_pulse = 1'b0; addr_ready = 1'b0;
            tick();
        end

        // Data override inside a window; address and addr_ready changes do not matter.
        write_pulse = 1'b1; addr = 7'd11; addr_ready = 1'b1; datain = 32'hDEAD_0011;
        tick();
        datain = 32'h0000_0555; addr = 7'd50;
        tick();
        write_pulse = 1'b0; addr_ready = 1'b0; datain = 32'hFFFF_FFFF;
        tick();
        ref_mem[11] = 32'h0000_0555;
        do_read(7'd11, 1'b1, "override_11");
        check("override_value", ref_dout, 32'h0000_0555);
        do_read(7'd50, 1'b1, "addr_locked_50");

        // Write without addr_ready is ignored.
        do_write(7'd5, 32'hBAD0_0005, 1'b0);
        do_read(7'd5, 1'b1, "noready_write_5");

        // Writes do not disturb dataout.
        do_read(7'd3, 1'b1, "read_3");
        do_write(7'd7, 32'h7777_0007, 1'b1);
        check("hold_after_w7", dataout, ref_mem[3]);
        do_write(7'd9, 32'h9999_0009, 1'b1);
        check("hold_after_w9", dataout, ref_mem[3]);

        // Read ignored without addr_ready.
        do_read(7'd9, 1'b0, "noready_read");

        // Read during WRITE returns pre-commit contents.
        old = ref_mem[30];
        write_pulse = 1'b1; addr = 7'd30; addr_ready = 1'b1; datain = 32'h3030_3030;
        tick();
        read_pulse = 1'b1;
        tick();
        check("read_in_window", dataout, old);
        read_pulse = 1'b0; write_pulse = 1'b0;
        tick();
        ref_mem[30] = 32'h3030_3030;
        ref_dout = old;
        do_read(7'd30, 1'b1, "after_commit_30");

        // Read edge and commit on the same cycle and address: old word.
        old = ref_mem[31];
        write_pulse = 1'b1; addr = 7'd31; addr_ready = 1'b1; datain = 32'h3131_3131;
        tick();
        write_pulse = 1'b0; read_pulse = 1'b1;
        tick();
        check("read_commit_same", dataout, old);
        ref_mem[31] = 32'h3131_3131;
        ref_dout = old;
        read_pulse = 1'b0; addr_ready = 1'b0;
        tick();
        do_read(7'd31, 1'b1, "after_same_31");

        // Reset mid-window at 20: dataout clears at once, no commit, memory survives.
        write_pulse = 1'b1; addr = 7'd20; addr_ready = 1'b1; datain = 32'h2020_2020;
        tick();
        #2 rst_n = 1'b0;
        #1 check("async_reset_dout", dataout, 32'h0);
        write_pulse = 1'b0; read_pulse = 1'b1; addr = 7'd60; addr_ready = 1'b1;
        tick();
        check("reset_held_dout", dataout, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        ref_dout = ref_mem[60];
        check("post_reset_high_read", dataout, ref_dout);
        read_pulse = 1'b0; addr_ready = 1'b0;
        tick();
        do_read(7'd20, 1'b1, "reset_discard_20");
        do_read(7'd100, 1'b1, "survive_100");

        // Held-high read_pulse yields one read from the address at the rising edge.
        read_pulse = 1'b1; addr = 7'd40; addr_ready = 1'b1;
        tick();
        ref_dout = ref_mem[40];
        check("held_read_first", dataout, ref_dout);
        for (int i = 0; i < 9; i++) begin
            addr = 7'($urandom_range(0, 127));
            tick();
            check("held_read_stay", dataout, ref_dout);
        end
        read_pulse = 1'b0; addr_ready = 1'b0;
        tick();

        // Randomized mix of write windows and reads.
        for (int n = 0; n < 150; n++) begin
            a   = 7'($urandom_range(0, 127));
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom();
                write_pulse = 1'b1; addr = a; addr_ready = rdy; datain = d;
                tick();
                extra = $urandom_range(0, 3);
                for (int k = 0; k < extra; k++) begin
                    d = $urandom();
                    datain = d;
                    addr = 7'($urandom_range(0, 127));
                    addr_ready = 1'($urandom_range(0, 1));
                    tick();
                end
                write_pulse = 1'b0;
                addr_ready = 1'($urandom_range(0, 1));
                tick();
                if (rdy) ref_mem[a] = d;
                check("rand_write_hold", dataout, ref_dout);
            end else begin
                do_read(a, rdy, "rand_read");
            end
        end
        for (int i = 0; i < 128; i += 9) begin
            do_read(7'(i), 1'b1, "final_sweep");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
